// File: rtl/blocking_port_arbiter_pkg.sv
// Shared types and reset constants for the blocking port arbiter.
package blocking_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2
  } blocking_port_arbiter_SECTIONS;

  localparam int unsigned XFER_CNT_W = 32;

  localparam blocking_port_arbiter_SECTIONS SECTION_RST  = ARB;
  localparam logic [XFER_CNT_W-1:0]         XFER_CNT_RST = '0;

endpackage

// File: rtl/blocking_port_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping at N_REQ.
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner_c,
  output logic             any_valid_c
);

  int idx;

  // Scan from farthest to nearest so the request closest to ptr is the last (winning) write.
  always_comb begin
    winner_c    = '0;
    any_valid_c = 1'b0;
    idx         = 0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (req[IDX_W'(idx)]) begin
        winner_c    = IDX_W'(idx);
        any_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/blocking_port_arbiter.sv
// Shares one blocking output channel between N_REQ blocking producers, one word per grant.
module blocking_port_arbiter
  import blocking_port_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ  = 4,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned IDX_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_sync,
  output logic [N_REQ-1:0]        req_notify,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_sync,
  output logic                    out_notify,
  output logic [IDX_W-1:0]        grant_id,
  output logic [XFER_CNT_W-1:0]   xfer_cnt
);

  blocking_port_arbiter_SECTIONS section_q, section_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [N_REQ-1:0]      req_notify_q, req_notify_d;
  logic                  out_notify_q, out_notify_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic [IDX_W-1:0] winner_c;
  logic             any_valid_c;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req         (req_sync),
    .ptr         (ptr_q),
    .winner_c    (winner_c),
    .any_valid_c (any_valid_c)
  );

  // Next-state and registered-output logic for the ARB/ACCEPT/SEND sections.
  always_comb begin
    section_d    = section_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    req_notify_d = req_notify_q;
    out_notify_d = out_notify_q;
    out_data_d   = out_data_q;
    xfer_cnt_d   = xfer_cnt_q;

    unique case (section_q)
      ARB: begin
        req_notify_d = '0;
        if (any_valid_c) begin
          grant_d      = winner_c;
          req_notify_d = N_REQ'(1) << winner_c;
          section_d    = ACCEPT;
        end
      end
      ACCEPT: begin
        req_notify_d = '0;
        if (req_sync[grant_q]) begin
          out_data_d   = req_data[int'(grant_q)*DATA_W +: DATA_W];
          out_notify_d = 1'b1;
          section_d    = SEND;
        end else begin
          // Withdrawn before acceptance: ptr stays so the same requester keeps its priority.
          section_d = ARB;
        end
      end
      SEND: begin
        if (out_sync) begin
          out_notify_d = 1'b0;
          xfer_cnt_d   = xfer_cnt_q + XFER_CNT_W'(1);
          ptr_d        = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
          section_d    = ARB;
        end
      end
      default: section_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      section_q    <= SECTION_RST;
      ptr_q        <= '0;
      grant_q      <= '0;
      req_notify_q <= '0;
      out_notify_q <= 1'b0;
      out_data_q   <= '0;
      xfer_cnt_q   <= XFER_CNT_RST;
    end else begin
      section_q    <= section_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      req_notify_q <= req_notify_d;
      out_notify_q <= out_notify_d;
      out_data_q   <= out_data_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  assign req_notify = req_notify_q;
  assign out_notify = out_notify_q;
  assign out_data   = out_data_q;
  assign grant_id   = grant_q;
  assign xfer_cnt   = xfer_cnt_q;

endmodule
